// File: rtl/cordic_phase_gen.sv
// Programmable phase accumulator feeding the cordic sin/cos core: fixed-frequency
// run, single or looping linear frequency sweep, with a sample-rate divider.
module cordic_phase_gen #(
  parameter int PHASE_W = 16,
  parameter int DIV_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [1:0]         cfg_mode,
  input  logic [PHASE_W-1:0] cfg_fstart,
  input  logic [PHASE_W-1:0] cfg_fstop,
  input  logic [PHASE_W-1:0] cfg_fstep,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic               start,
  input  logic               stop,
  output logic [PHASE_W-1:0] deg,
  output logic               deg_valid,
  output logic               busy,
  output logic               sweep_done,
  output logic [1:0]         state_dbg
);

  // Config handshake: a word transfers on any edge where cfg_valid && cfg_ready;
  // cfg_ready is high only in IDLE, so config never changes during generation.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, SWEEP = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [1:0]         mode_q;
  logic [PHASE_W-1:0] fstart_q, fstop_q, fstep_q, freq_q;
  logic [DIV_W-1:0]   div_q, cnt_q;

  logic               cfg_accept, tick, pass_end;
  logic [1:0]         eff_mode;
  logic [PHASE_W-1:0] eff_fstart, freq_next;
  logic [PHASE_W:0]   freq_sum;

  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

  always_comb begin
    cfg_accept = cfg_valid && (state_q == IDLE);
    // A config word arriving together with start takes effect immediately.
    eff_mode   = cfg_accept ? cfg_mode   : mode_q;
    eff_fstart = cfg_accept ? cfg_fstart : fstart_q;
    tick       = (cnt_q == div_q);
    pass_end   = (freq_q >= fstop_q);
    // One extra bit so an overflowing step clamps to fstop instead of wrapping.
    freq_sum   = {1'b0, freq_q} + {1'b0, fstep_q};
    freq_next  = (freq_sum > {1'b0, fstop_q}) ? fstop_q : freq_sum[PHASE_W-1:0];

    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (eff_mode)
            2'b01:        state_d = RUN;
            2'b10, 2'b11: state_d = SWEEP;
            default:      state_d = IDLE;
          endcase
        end
      end
      RUN:     if (stop) state_d = IDLE;
      SWEEP: begin
        if (stop) state_d = IDLE;
        else if (tick && pass_end && !mode_q[0]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      fstart_q   <= '0;
      fstop_q    <= '0;
      fstep_q    <= PHASE_W'(1);
      div_q      <= '0;
      freq_q     <= '0;
      cnt_q      <= '0;
      deg        <= '0;
      deg_valid  <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      deg_valid  <= 1'b0;
      sweep_done <= 1'b0;
      if (cfg_accept) begin
        mode_q   <= cfg_mode;
        fstart_q <= cfg_fstart;
        fstop_q  <= cfg_fstop;
        fstep_q  <= (cfg_fstep == '0) ? PHASE_W'(1) : cfg_fstep;
        div_q    <= cfg_div;
      end
      case (state_q)
        IDLE: begin
          if (start && (eff_mode != 2'b00)) begin
            deg    <= '0;
            freq_q <= eff_fstart;
            cnt_q  <= '0;
          end
        end
        RUN, SWEEP: begin
          // stop wins over a coinciding tick: no strobe, phase held.
          if (!stop) begin
            if (tick) begin
              cnt_q     <= '0;
              deg       <= deg + freq_q;
              deg_valid <= 1'b1;
              if (state_q == SWEEP) begin
                if (pass_end) begin
                  sweep_done <= 1'b1;
                  if (mode_q[0]) freq_q <= fstart_q;
                end else begin
                  freq_q <= freq_next;
                end
              end
            end else begin
              cnt_q <= cnt_q + DIV_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
